// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds it for LATENCY
// cycles, then commits the access and returns the word with a one-cycle rvalid pulse.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 30;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [WW-1:0]   word_q, word_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  logic            is_idle_c;
  logic            op_we_c;
  logic [3:0]      op_be_c;
  logic [WW-1:0]   op_word_c;
  logic [31:0]     op_wdata_c;
  logic            in_range_c;
  logic [31:0]     rd_word_c;
  logic [31:0]     merged_c;
  logic            commit_c;
  logic            mem_we_c;
  logic            unused_addr_c;

  assign unused_addr_c = ^addr[1:0];

  // With LATENCY=1 the commit happens on the accepting edge, so use live inputs in IDLE.
  always_comb begin
    is_idle_c  = (state_q == S_IDLE);
    op_we_c    = is_idle_c ? we          : we_q;
    op_be_c    = is_idle_c ? be          : be_q;
    op_word_c  = is_idle_c ? addr[31:2]  : word_q;
    op_wdata_c = is_idle_c ? wdata       : wdata_q;
    in_range_c = (op_word_c < WW'(DEPTH));
    rd_word_c  = in_range_c ? mem[op_word_c[AW-1:0]] : '0;
    for (int i = 0; i < 4; i++) begin
      merged_c[8*i +: 8] = op_be_c[i] ? op_wdata_c[8*i +: 8] : rd_word_c[8*i +: 8];
    end
  end

  // Next-state and response logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    be_d     = be_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    commit_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          be_d    = be;
          word_d  = addr[31:2];
          wdata_d = wdata;
          cnt_d   = CW'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = S_WAIT;
          end else begin
            state_d  = S_RESP;
            commit_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_RESP;
          commit_c = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit_c) begin
      rvalid_d = 1'b1;
      if (in_range_c) begin
        rdata_d = op_we_c ? merged_c : rd_word_c;
      end else begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  assign mem_we_c = commit_c && in_range_c && op_we_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      be_q     <= be_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array is not reset; a reset on the commit edge drops the pending store.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem[op_word_c[AW-1:0]] <= merged_c;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign stall  = req && !rvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance (a) and a LATENCY=1 instance (b).
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic        ready_a, rvalid_a, stall_a, err_a;
  logic [31:0] rdata_a;
  logic        ready_b, rvalid_b, stall_b, err_b;
  logic [31:0] rdata_b;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a), .stall(stall_a), .err(err_a)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b), .stall(stall_b), .err(err_b)
  );

  // Scoreboard: every response pulse pops one expected entry.
  always @(negedge clk) begin
    if (rvalid_a || rvalid_b) begin
      exp_t        e;
      logic [31:0] got_r;
      logic        got_e;
      got_r = rvalid_a ? rdata_a : rdata_b;
      got_e = rvalid_a ? err_a : err_b;
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_rvalid rdata=%h err=%b at %0t", got_r, got_e, $time);
      end else begin
        e = sb_q.pop_front();
        if (got_r !== e.rdata || got_e !== e.err)
          $display("FAIL sb_response got rdata=%h err=%b exp rdata=%h err=%b at %0t",
                   got_r, got_e, e.rdata, e.err, $time);
        else passes++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Drive one access (starting #1 after a posedge), wait for its rvalid, return latency.
  task automatic issue(input bit sel, input logic we_i, input logic [3:0] be_i,
                       input logic [31:0] a_i, input logic [31:0] w_i,
                       input logic [31:0] exp_r, input logic exp_e, output int lat);
    exp_t e;
    bit   seen;
    e.rdata = exp_r;
    e.err   = exp_e;
    sb_q.push_back(e);
    we = we_i; be = be_i; addr = a_i; wdata = w_i;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sel ? rvalid_b : rvalid_a) seen = 1'b1;
      else lat++;
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL issue_timeout addr=%h no rvalid within 20 cycles", a_i);
      lat = -1;
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    we = 1'b1; be = 4'hF; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready_a got %b exp 1", ready_a); else passes++;
    checks++; if (rvalid_a !== 1'b0) $display("FAIL reset_rvalid_a got %b exp 0", rvalid_a); else passes++;
    checks++; if (rdata_a !== 32'h0) $display("FAIL reset_rdata_a got %h exp 0", rdata_a); else passes++;
    checks++; if (err_a !== 1'b0) $display("FAIL reset_err_a got %b exp 0", err_a); else passes++;
    checks++; if (ready_b !== 1'b1) $display("FAIL reset_ready_b got %b exp 1", ready_b); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    logic [5:0] st, rv;
    exp_t e;
    e.rdata = 32'hDEADBEEF; e.err = 1'b0;
    sb_q.push_back(e);
    we = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'hDEADBEEF; req_a = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      st[c] = stall_a;
      rv[c] = rvalid_a;
      @(posedge clk); #1;
      if (c == 2) begin
        sb_q.push_back(e);
        we = 1'b0; be = 4'h0; wdata = 32'h0;
      end
    end
    req_a = 1'b0;
    checks++; if (st !== 6'b011011) $display("FAIL basic_stall got %b exp 011011", st); else passes++;
    checks++; if (rv !== 6'b100100) $display("FAIL basic_rvalid got %b exp 100100", rv); else passes++;
  endtask

  task automatic test_byte_lane;
    int lat;
    issue(1'b0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, 32'hDEADAAEF, 1'b0, lat);
    checks++; if (lat !== 2) $display("FAIL byte_lane_latency got %0d exp 2", lat); else passes++;
    issue(1'b0, 1'b0, 4'b0000, 32'h13, 32'h0, 32'hDEADAAEF, 1'b0, lat);
  endtask

  task automatic test_zero_be;
    int lat;
    issue(1'b0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'hDEADAAEF, 1'b0, lat);
    issue(1'b0, 1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, lat);
  endtask

  task automatic test_out_of_range;
    int lat;
    issue(1'b0, 1'b1, 4'hF, 32'h0, 32'h55AA0001, 32'h55AA0001, 1'b0, lat);
    issue(1'b0, 1'b1, 4'hF, 32'h100, 32'h12345678, 32'h0, 1'b1, lat);
    checks++; if (lat !== 2) $display("FAIL oor_latency got %0d exp 2", lat); else passes++;
    issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h55AA0001, 1'b1, lat);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (err_a !== 1'b1) $display("FAIL oor_err_sticky got %b exp 1", err_a); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(1'b0, 1'b1, 4'hF, 32'h20, 32'h0BADC0DE, 32'h0BADC0DE, 1'b1, lat);
    we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'hCAFEF00D; req_a = 1'b1;
    @(negedge clk);
    checks++; if (stall_a !== 1'b1) $display("FAIL rst_mid_stall got %b exp 1", stall_a); else passes++;
    @(posedge clk); #1;
    reset = 1'b1; req_a = 1'b0;
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b0) $display("FAIL rst_mid_rvalid_t1 got %b exp 0", rvalid_a); else passes++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) $display("FAIL rst_mid_ready got %b exp 1", ready_a); else passes++;
    checks++; if (rvalid_a !== 1'b0) $display("FAIL rst_mid_rvalid_t2 got %b exp 0", rvalid_a); else passes++;
    checks++; if (err_a !== 1'b0) $display("FAIL rst_mid_err got %b exp 0", err_a); else passes++;
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0BADC0DE, 1'b0, lat);
  endtask

  task automatic test_latency1;
    logic [3:0] rv;
    int lat;
    exp_t e;
    e.rdata = 32'h11111111; e.err = 1'b0;
    sb_q.push_back(e);
    we = 1'b1; be = 4'hF; addr = 32'h4; wdata = 32'h11111111; req_b = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rv[c] = rvalid_b;
      @(posedge clk); #1;
      if (c == 1) begin
        sb_q.push_back(e);
        we = 1'b0; be = 4'h0; wdata = 32'h0;
      end
    end
    req_b = 1'b0;
    checks++; if (rv !== 4'b1010) $display("FAIL lat1_rvalid got %b exp 1010", rv); else passes++;
    issue(1'b1, 1'b1, 4'b1000, 32'h4, 32'hAB000000, 32'hAB111111, 1'b0, lat);
    checks++; if (lat !== 1) $display("FAIL lat1_latency got %0d exp 1", lat); else passes++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lane();
    test_zero_be();
    test_out_of_range();
    test_reset_mid();
    test_latency1();
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover got %0d pending exp 0", sb_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
